pc_stack: RTL
=============

# pc_stack

Program counter with a hardware return-address stack for the processor core. It supports sequential fetch, absolute jump, subroutine call and return, and stall, all within one cycle. It replaces the plain counter in cores that need nested subroutines without spending data memory on return addresses. It sits between the instruction decoder (which drives the commands) and the instruction memory address input (`addr`).

## Interface
- `NBITS`, 8: width of instruction address, jump target and stack entries.
- `SDEPTH`, 8: number of return-stack entries; integer >= 2.
- `SBITS`, `$clog2(SDEPTH+1)`: width of the `depth` output; derived, not overridden.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  advance enable; 0 = stall, all state holds, all commands ignored.
- `load`  in  1  absolute jump to `data`.
- `call`  in  1  push return address, jump to `data`.
- `ret`  in  1  pop return address and jump to it.
- `data`  in  NBITS  jump/call target.
- `addr`  out  NBITS  current instruction address (the counter register).
- `top`  out  NBITS  top-of-stack value; 0 when stack empty.
- `depth`  out  SBITS  number of valid stack entries, 0..SDEPTH.
- `ovf`  out  1  sticky: a push occurred while full.
- `unf`  out  1  sticky: a pop occurred while empty.
- `err`  out  1  sticky: `call` and `ret` asserted together with `en`=1.

## Operation
- State: counter `cnt` (drives `addr`), SDEPTH x NBITS stack array, circular stack pointer `sp` (mod SDEPTH), `depth` counter, three sticky flags.
- Command priority when `en`=1: `ret` > `call` > `load` > increment. Only the highest-priority command executes.
- Increment: `cnt <= cnt + 1`.
- Load: `cnt <= data + 1`. The target-plus-one rule matches the existing fetch pipeline and applies to every redirect.
- Call: write `cnt` (current `addr`) to `stack[sp]`, `sp <= sp + 1`, `depth <= min(depth+1, SDEPTH)`, `cnt <= data + 1`.
- Call when `depth == SDEPTH`: the entry is still written at `sp`, overwriting the oldest entry (circular), `sp` advances, `depth` stays at SDEPTH, and `ovf <= 1`.
- Ret with `depth > 0`: `sp <= sp - 1`, `depth <= depth - 1`, `cnt <= stack[sp-1] + 1`.
- Ret with `depth == 0`: no redirect, `cnt <= cnt + 1`, `sp` and `depth` unchanged, `unf <= 1`.
- `call` and `ret` both high: `err <= 1`, and the ret executes exactly as above. `load` is also ignored whenever `call` or `ret` wins.
- `top` = `stack[sp-1]` when `depth > 0`, else 0. It is combinational from registered state and reflects a push or pop in the cycle after the edge.
- Arithmetic is modulo 2^NBITS for `cnt` and all targets: `cnt` all-ones increments to 0, and `load` of all-ones gives `cnt` = 0. `sp` wraps modulo SDEPTH.
- Sticky flags clear only on `rst`.

## Timing
- Reset (async, immediate on `rst` rising, held while high): `addr` = 0, `sp` = 0, `depth` = 0, `top` = 0, `ovf` = `unf` = `err` = 0. Stack array contents are don't-care and not reset.
- First rising edge with `rst` low and `en`=1 gives `addr` = 1.
- Every command has one-cycle latency. Inputs are sampled on edge N, and the new `addr`/`top`/`depth`/flags are visible after edge N.
- `en`=0 for any number of cycles: every output holds its value, and commands presented during the stall are lost (not queued).
- Reset asserted mid-sequence (e.g. during nested calls) discards the stack immediately. The next return after reset is an underflow.
- No combinational path from inputs to outputs.

## Test plan
- Reset/increment: assert `rst`, release, run 5 cycles with `en`=1 -> `addr` 1,2,3,4,5. `depth`=0, `top`=0, flags 0. Hold `en`=0 for 3 cycles -> `addr` stays 5.
- Jump and wrap (NBITS=8): `load` `data`=0xFE -> `addr`=0xFF, next cycle 0x00. `load` `data`=0xFF -> `addr`=0x00.
- Nested call/return: at `addr`=0x10 `call` 0x40 -> `addr`=0x41, `top`=0x10, `depth`=1. At 0x43 `call` 0x80 -> `addr`=0x81, `top`=0x43, `depth`=2. `ret` -> `addr`=0x44, `top`=0x10, `depth`=1. `ret` -> `addr`=0x11, `depth`=0.
- Overflow (SDEPTH=4): 5 consecutive calls pushing 1,2,3,4,5 -> `depth`=4, `ovf`=1. Then 4 rets -> returns to 6,5,4,3 (+1 rule), `depth`=0. A 5th `ret` -> `unf`=1, `addr` just increments.
- Conflict and priority: `call`+`ret`+`load` together with `depth`=1, `top`=0x20 -> `addr`=0x21, `depth`=0, `err`=1. The same inputs with `en`=0 -> no change, `err` unchanged.
- Async reset mid-operation: with `depth`=3, pulse `rst` between clock edges -> `addr`, `depth`, `top` and all flags go to 0 before the next edge. A following `ret` sets `unf`.

Source files
------------

// File: rtl/pc_stack.sv
// Program counter with a circular hardware return-address stack.
// Redirects (load, call, ret) land on target + 1 to match the fetch pipeline.
module pc_stack #(
  parameter int unsigned NBITS  = 8,
  parameter int unsigned SDEPTH = 8,
  localparam int unsigned SBITS = $clog2(SDEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  input  logic [NBITS-1:0] data,
  output logic [NBITS-1:0] addr,
  output logic [NBITS-1:0] top,
  output logic [SBITS-1:0] depth,
  output logic             ovf,
  output logic             unf,
  output logic             err
);

  localparam int unsigned PBITS = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

  logic [NBITS-1:0] cnt_q, cnt_d;
  logic [PBITS-1:0] sp_q, sp_d;
  logic [SBITS-1:0] depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             err_q, err_d;
  logic [NBITS-1:0] stack_q [SDEPTH];

  logic [PBITS-1:0] sp_inc, sp_dec;
  logic             push;
  logic             empty, full;

  // Stack pointer neighbours, wrapped explicitly so non-power-of-two depths work.
  always_comb begin
    sp_inc = (sp_q == PBITS'(SDEPTH - 1)) ? '0 : sp_q + PBITS'(1);
    sp_dec = (sp_q == '0) ? PBITS'(SDEPTH - 1) : sp_q - PBITS'(1);
    empty  = (depth_q == '0);
    full   = (depth_q == SBITS'(SDEPTH));
  end

  // Next-state decode: ret > call > load > increment, all gated by en.
  always_comb begin
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    err_d   = err_q;
    push    = 1'b0;
    if (en) begin
      if (call && ret) err_d = 1'b1;
      if (ret) begin
        if (!empty) begin
          sp_d    = sp_dec;
          depth_d = depth_q - SBITS'(1);
          cnt_d   = stack_q[sp_dec] + NBITS'(1);
        end else begin
          cnt_d = cnt_q + NBITS'(1);
          unf_d = 1'b1;
        end
      end else if (call) begin
        // A full stack still takes the push, overwriting the oldest entry.
        push  = 1'b1;
        sp_d  = sp_inc;
        cnt_d = data + NBITS'(1);
        if (full) ovf_d = 1'b1;
        else      depth_d = depth_q + SBITS'(1);
      end else if (load) begin
        cnt_d = data + NBITS'(1);
      end else begin
        cnt_d = cnt_q + NBITS'(1);
      end
    end
  end

  // Control state and sticky flags, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      sp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      err_q   <= err_d;
    end
  end

  // Stack storage is not reset; depth alone marks which entries are valid.
  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q] <= cnt_q;
  end

  // Outputs come straight from registered state.
  always_comb begin
    addr  = cnt_q;
    top   = empty ? '0 : stack_q[sp_dec];
    depth = depth_q;
    ovf   = ovf_q;
    unf   = unf_q;
    err   = err_q;
  end

endmodule
